// File: rtl/ssdecode.sv
// ssdecode: watches a two-digit, active-low 7-segment display (seg1 = tens,
// seg0 = ones). Once the pattern has been stable long enough, it reports the
// value 0..63 exactly once per stable occurrence. An out_valid pulse reports a
// legal value and an err pulse reports an illegal pattern.
// Optional build macro: SSDECODE_DP_CHECK_EN. When it is defined, a lit
// decimal point (bit7 = 0) on either digit makes the pattern illegal. When it
// is undefined, bit7 is ignored.
module ssdecode #(
   parameter int unsigned STABLE_CYCLES = 4   // legal range 2..15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seg0,
   input  logic [7:0] seg1,
   output logic [5:0] data,
   output logic       out_valid,
   output logic       err,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_QUAL   = 2'd1,
      ST_DECODE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   typedef struct packed {
      logic       ok;
      logic [3:0] val;
   } digit_t;

   localparam logic [3:0]  CNT_LAST = 4'(STABLE_CYCLES - 1);
   localparam logic [15:0] PAT_NONE = 16'hFFFF;

   // Map the seven segment bits (active low) of one digit to its value.
   function automatic digit_t seg_to_digit(input logic [6:0] seg);
      digit_t d;
      d = '{ok: 1'b1, val: 4'd0};
      case (seg)
         7'h40:   d.val = 4'd0;
         7'h79:   d.val = 4'd1;
         7'h24:   d.val = 4'd2;
         7'h30:   d.val = 4'd3;
         7'h19:   d.val = 4'd4;
         7'h12:   d.val = 4'd5;
         7'h02:   d.val = 4'd6;
         7'h78:   d.val = 4'd7;
         7'h00:   d.val = 4'd8;
         7'h10:   d.val = 4'd9;
         default: d.ok  = 1'b0;   // blank (0x7F) and every other code
      endcase
      return d;
   endfunction

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_sample;     // registered {seg1, seg0}
   logic [15:0] r_prev;       // sample from the previous cycle
   logic [15:0] r_cand;       // pattern that completed qualification
   logic [15:0] r_last;       // last reported pattern (legal or not)
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        w_cand_load;
   logic [5:0]  r_data;
   logic        r_valid;
   logic        r_err;

   digit_t      w_tens;
   digit_t      w_ones;
   logic [6:0]  w_value;
   logic        w_dp_ok;
   logic        w_legal;

   assign w_tens  = seg_to_digit(r_cand[14:8]);
   assign w_ones  = seg_to_digit(r_cand[6:0]);
   assign w_value = 7'(w_tens.val) * 7'd10 + 7'(w_ones.val);

`ifdef SSDECODE_DP_CHECK_EN
   assign w_dp_ok = r_cand[15] & r_cand[7];
`else
   assign w_dp_ok = 1'b1;
`endif

   assign w_legal = w_tens.ok & w_ones.ok & w_dp_ok & (w_value <= 7'd63);

   // State register; reset has priority over every other event.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples its pre-edge inputs, whatever order the blocks run in.
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic and stability-counter control.
   always_comb begin
      // NOTE: give every output a default first, so that no path through the
      // case statement leaves a signal unassigned and infers a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_load = 1'b0;
      case (r_state)
         ST_IDLE, ST_HOLD: begin
            if (r_sample != r_last) begin
               w_state_nxt = ST_QUAL;
               w_cnt_nxt   = '0;
            end
         end
         ST_QUAL: begin
            if (r_sample != r_prev) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_DECODE;
               w_cand_load = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         ST_DECODE: w_state_nxt = ST_HOLD;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Input sampling, stability counter and reported-pattern bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sample <= PAT_NONE;
         r_prev   <= PAT_NONE;
         r_cand   <= PAT_NONE;
         r_last   <= PAT_NONE;
         r_cnt    <= '0;
      end else begin
         r_sample <= {seg1, seg0};
         r_prev   <= r_sample;
         r_cnt    <= w_cnt_nxt;
         if (w_cand_load)           r_cand <= r_sample;
         if (r_state == ST_DECODE)  r_last <= r_cand;
      end
   end

   // Result registers: a one-cycle report in the cycle after DECODE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (r_state == ST_DECODE) begin
            if (w_legal) begin
               r_data  <= w_value[5:0];
               r_valid <= 1'b1;
            end else begin
               r_err   <= 1'b1;
            end
         end
      end
   end

   assign data      = r_data;
   assign out_valid = r_valid;
   assign err       = r_err;
   assign busy      = (r_state == ST_QUAL) || (r_state == ST_DECODE);

endmodule

// File: tb/tb_ssdecode.sv
// tb_ssdecode: directed scenarios plus a randomized segment stream. The stream
// is checked against a model that works on whole stable segments of input.
module tb_ssdecode;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] seg0;
   logic [7:0] seg1;
   logic [5:0] data;
   logic       out_valid;
   logic       err;
   logic       busy;

   int tests_run    = 0;
   int tests_failed = 0;

   // Active-low segment codes for digits 0..9.
   logic [6:0] digit_codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   ssdecode #(.STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg0      (seg0),
      .seg1      (seg1),
      .data      (data),
      .out_valid (out_valid),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // One rising edge; outputs are observed 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decode: look each digit up in the table, then add the digits.
   function automatic void ref_decode(input logic [15:0] pat, output bit legal,
                                      output int value);
      int t;
      int o;
      t = -1;
      o = -1;
      for (int i = 0; i < 10; i++) begin
         if (pat[14:8] == digit_codes[i]) t = i;
         if (pat[6:0]  == digit_codes[i]) o = i;
      end
      value = (t < 0 || o < 0) ? -1 : t * 10 + o;
      legal = (t >= 0) && (o >= 0) && (value <= 63);
`ifdef SSDECODE_DP_CHECK_EN
      if (pat[15] == 1'b0 || pat[7] == 1'b0) legal = 1'b0;
`endif
   endfunction

   function automatic logic [7:0] gen_digit();
      logic dp;
      dp = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) return 8'($urandom);
      return {dp, digit_codes[$urandom_range(0, 9)]};
   endfunction

   // Hold one pattern for nticks edges and summarise the pulses that appear.
   // Tick k observes edge N+k-1, where edge N is the first edge that samples it.
   task automatic hold_pattern(input logic [7:0] s1, input logic [7:0] s0,
                               input int nticks, output int n_valid,
                               output int n_err, output int first_valid,
                               output int first_err, output int n_busy);
      n_valid = 0; n_err = 0; first_valid = -1; first_err = -1; n_busy = 0;
      seg1 = s1;
      seg0 = s0;
      for (int k = 1; k <= nticks; k++) begin
         tick();
         if (out_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = k;
         end
         if (err) begin
            n_err++;
            if (first_err < 0) first_err = k;
         end
         if (busy) n_busy++;
      end
   endtask

   task automatic test_reset();
      int nv, ne, fv, fe, nb;
      rst = 1'b1; seg1 = 8'hFF; seg0 = 8'hFF;
      tick(); tick();
      tests_run++;
      if ({data, out_valid, err, busy} !== 9'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got data=%0d v=%b e=%b b=%b, need all 0", data, out_valid, err, busy);
      end
      rst = 1'b0;
      hold_pattern(8'hFF, 8'hFF, 15, nv, ne, fv, fe, nb);
      tests_run++;
      if (nv + ne !== 0) begin
         tests_failed++;
         $display("FAIL ffff_not_reported: got %0d pulses, need 0", nv + ne);
      end
      tests_run++;
      if (nb !== 0) begin
         tests_failed++;
         $display("FAIL ffff_not_busy: busy high %0d cycles, need 0", nb);
      end
   endtask

   task automatic test_latency();
      logic exp_v, exp_b;
      seg1 = 8'h99; seg0 = 8'hA4;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp_v = (k == S + 3);
         exp_b = (k >= 2 && k <= S + 2);
         tests_run++;
         if (out_valid !== exp_v || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_pulse tick %0d: got v=%b e=%b, need v=%b e=0", k, out_valid, err, exp_v);
         end
         tests_run++;
         if (busy !== exp_b) begin
            tests_failed++;
            $display("FAIL latency_busy tick %0d: got %b, need %b", k, busy, exp_b);
         end
         if (k == S + 3) begin
            tests_run++;
            if (data !== 6'd42) begin
               tests_failed++;
               $display("FAIL latency_data: got %0d, need 42", data);
            end
         end
      end
   endtask

   task automatic test_range();
      int nv, ne, fv, fe, nb;
      hold_pattern(8'h82, 8'hB0, S + 6, nv, ne, fv, fe, nb);
      tests_run++;
      if (nv !== 1 || ne !== 0 || fv !== S + 3 || data !== 6'd63) begin
         tests_failed++;
         $display("FAIL value_63: got v=%0d e=%0d at %0d data=%0d, need v=1 e=0 at %0d data=63", nv, ne, fv, data, S + 3);
      end
      hold_pattern(8'h82, 8'h99, S + 6, nv, ne, fv, fe, nb);
      tests_run++;
      if (ne !== 1 || nv !== 0 || fe !== S + 3 || data !== 6'd63) begin
         tests_failed++;
         $display("FAIL value_64_err: got v=%0d e=%0d at %0d data=%0d, need v=0 e=1 at %0d data=63", nv, ne, fe, data, S + 3);
      end
   endtask

   task automatic test_bounce();
      int pulses, busy_low, nv, ne, fv, fe, nb;
      pulses = 0; busy_low = 0;
      seg1 = 8'hC0;
      for (int k = 0; k < 20; k++) begin
         seg0 = ((k / 2) % 2 == 0) ? 8'hC0 : 8'hF9;
         tick();
         if (out_valid || err) pulses++;
         if (k >= 1 && !busy) busy_low++;
      end
      tests_run++;
      if (pulses !== 0) begin
         tests_failed++;
         $display("FAIL bounce_no_pulse: got %0d pulses, need 0", pulses);
      end
      tests_run++;
      if (busy_low !== 0) begin
         tests_failed++;
         $display("FAIL bounce_busy: busy low %0d cycles, need 0", busy_low);
      end
      hold_pattern(8'hC0, 8'hF9, S + 6, nv, ne, fv, fe, nb);
      tests_run++;
      if (nv !== 1 || ne !== 0 || data !== 6'd1) begin
         tests_failed++;
         $display("FAIL bounce_settle: got v=%0d e=%0d data=%0d, need v=1 e=0 data=1", nv, ne, data);
      end
   endtask

   task automatic test_hold_abort();
      int nv, ne, fv, fe, nb, pulses;
      hold_pattern(8'hC0, 8'hC0, 50, nv, ne, fv, fe, nb);
      tests_run++;
      if (nv !== 1 || ne !== 0 || data !== 6'd0) begin
         tests_failed++;
         $display("FAIL hold_once: got v=%0d e=%0d data=%0d, need v=1 e=0 data=0", nv, ne, data);
      end
      pulses = 0;
      seg1 = 8'hC0; seg0 = 8'hA4;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (out_valid || err) pulses++;
      end
      rst = 1'b1;
      tick();
      if (out_valid || err) pulses++;
      tests_run++;
      if (pulses !== 0 || {data, out_valid, err, busy} !== 9'h0) begin
         tests_failed++;
         $display("FAIL qual_abort: got pulses=%0d data=%0d v=%b e=%b b=%b, need all 0", pulses, data, out_valid, err, busy);
      end
      rst = 1'b0;
      hold_pattern(8'hC0, 8'hA4, S + 6, nv, ne, fv, fe, nb);
      tests_run++;
      if (nv !== 1 || fv !== S + 3 || data !== 6'd2) begin
         tests_failed++;
         $display("FAIL post_reset_report: got v=%0d at %0d data=%0d, need v=1 at %0d data=2", nv, fv, data, S + 3);
      end
   endtask

   task automatic test_decode_abort();
      int pulses, nv, ne, fv, fe, nb;
      pulses = 0;
      seg1 = 8'hC0; seg0 = 8'hB0;
      for (int k = 0; k < S + 2; k++) begin
         tick();
         if (out_valid || err) pulses++;
      end
      tests_run++;
      if (busy !== 1'b1 || pulses !== 0) begin
         tests_failed++;
         $display("FAIL decode_reached: got busy=%b pulses=%0d, need busy=1 pulses=0", busy, pulses);
      end
      rst = 1'b1;
      tick();
      tests_run++;
      if ({data, out_valid, err, busy} !== 9'h0) begin
         tests_failed++;
         $display("FAIL decode_abort: got data=%0d v=%b e=%b b=%b, need all 0", data, out_valid, err, busy);
      end
      rst = 1'b0;
      hold_pattern(8'hFF, 8'hFF, 12, nv, ne, fv, fe, nb);
      tests_run++;
      if (nv + ne !== 0 || data !== 6'd0) begin
         tests_failed++;
         $display("FAIL ffff_after_abort: got pulses=%0d data=%0d, need 0 and 0", nv + ne, data);
      end
   endtask

   task automatic test_dp();
      int nv, ne, fv, fe, nb;
      hold_pattern(8'h19, 8'h24, S + 6, nv, ne, fv, fe, nb);
      tests_run++;
`ifdef SSDECODE_DP_CHECK_EN
      if (ne !== 1 || nv !== 0 || data !== 6'd0) begin
         tests_failed++;
         $display("FAIL dp_checked: got v=%0d e=%0d data=%0d, need v=0 e=1 data=0", nv, ne, data);
      end
`else
      if (nv !== 1 || ne !== 0 || data !== 6'd42) begin
         tests_failed++;
         $display("FAIL dp_ignored: got v=%0d e=%0d data=%0d, need v=1 e=0 data=42", nv, ne, data);
      end
`endif
   endtask

   task automatic test_blank();
      int nv, ne, fv, fe, nb;
      hold_pattern(8'hC0, 8'hA4, S + 6, nv, ne, fv, fe, nb);
      tests_run++;
      if (nv !== 1 || data !== 6'd2) begin
         tests_failed++;
         $display("FAIL blank_setup: got v=%0d data=%0d, need v=1 data=2", nv, data);
      end
      hold_pattern(8'hFF, 8'hC0, S + 6, nv, ne, fv, fe, nb);
      tests_run++;
      if (ne !== 1 || nv !== 0 || fe !== S + 3) begin
         tests_failed++;
         $display("FAIL blank_tens_ff: got v=%0d e=%0d at %0d, need v=0 e=1 at %0d", nv, ne, fe, S + 3);
      end
      hold_pattern(8'h7F, 8'hF9, S + 6, nv, ne, fv, fe, nb);
      tests_run++;
      if (ne !== 1 || nv !== 0 || data !== 6'd2) begin
         tests_failed++;
         $display("FAIL blank_tens_7f: got v=%0d e=%0d data=%0d, need v=0 e=1 data=2", nv, ne, data);
      end
   endtask

   // Random stream of segments: short ones (<= S edges) must never report,
   // long ones report once, S+2 edges after their first edge.
   task automatic test_random();
      logic [15:0] seq [$];
      bit          ev_v [$];
      bit          ev_e [$];
      logic [5:0]  ev_d [$];
      logic [15:0] pat;
      logic [15:0] prev;
      logic [5:0]  exp_data;
      bit          legal;
      int          value, len, start;

      rst = 1'b1; seg1 = 8'hFF; seg0 = 8'hFF;
      tick(); tick();
      rst = 1'b0;

      prev = 16'hFFFF;
      for (int s = 0; s < 30; s++) begin
         do pat = {gen_digit(), gen_digit()}; while (pat == prev || pat == 16'hFFFF);
         if (s == 29 || $urandom_range(0, 1) == 1) len = int'($urandom_range(S + 3, S + 8));
         else                                      len = int'($urandom_range(1, S));
         start = seq.size();
         for (int i = 0; i < len; i++) begin
            seq.push_back(pat);
            ev_v.push_back(1'b0);
            ev_e.push_back(1'b0);
            ev_d.push_back(6'd0);
         end
         if (len >= S + 3) begin
            ref_decode(pat, legal, value);
            if (legal) begin
               ev_v[start + S + 2] = 1'b1;
               ev_d[start + S + 2] = 6'(value);
            end else begin
               ev_e[start + S + 2] = 1'b1;
            end
         end
         prev = pat;
      end

      exp_data = 6'd0;
      for (int k = 0; k < seq.size(); k++) begin
         seg1 = seq[k][15:8];
         seg0 = seq[k][7:0];
         tick();
         if (ev_v[k]) exp_data = ev_d[k];
         tests_run++;
         if (out_valid !== ev_v[k] || err !== ev_e[k] || data !== exp_data) begin
            tests_failed++;
            $display("FAIL random edge %0d pat=%h: got v=%b e=%b data=%0d, need v=%b e=%b data=%0d",
                     k, seq[k], out_valid, err, data, ev_v[k], ev_e[k], exp_data);
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      seg0 = 8'hFF;
      seg1 = 8'hFF;
      test_reset();
      test_latency();
      test_range();
      test_bounce();
      test_hold_abort();
      test_decode_abort();
      test_dp();
      test_blank();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
